add_sub_issue_stage: RTL and testbench

Operand-issue and result-capture stage wrapped around the team's combinational 64-bit carry-lookahead adder. Accepts add/subtract ops over a valid/ready handshake and drives the adder's a/b/c_in from a one-entry operand register. Captures sum/c_out plus a flag set into a small result FIFO. Keeps an architectural carry flag so multi-word ADC/SBB chains work across consecutive ops.

---
 rtl/add_sub_issue_stage.sv | 167 ++++++++++++++++
 tb/tb_add_sub_issue_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_issue_stage.sv
// Operand-issue / result-capture stage around an external 64-bit CLA adder; ADD/SUB/ADC/SBB with a carried flag.
// Latency: accept at edge N, retire into result FIFO at N+1, out_valid in the following cycle; 1 op/cycle.
// Backpressure: S1 holds (adder inputs stable) while the FIFO is full; ADD_SUB_SAT_EN enables signed saturation of ADD/SUB.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign pop_vld  = (count != '0);
  assign pop      = pop_vld & pop_rdy;
  // A pop on the same edge frees the slot, so a full FIFO can still take a push.
  assign push_rdy = (count != CW'(DEPTH)) | pop;
  assign push     = push_vld & push_rdy;
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module add_sub_issue_stage #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_c_in,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic             carry_flag
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;
  } res_t;

  logic             s1_vld;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_retire;
  logic             fifo_push_rdy;
  logic             accept;
  logic             res_v;
  logic [WIDTH-1:0] res_sum;
  res_t             push_dat;
  res_t             head_dat;

  assign accept   = in_valid & in_ready;
  assign in_ready = ~rst & (~s1_vld | s1_retire);
  assign s1_retire = s1_vld & fifo_push_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_op  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_op  <= in_op;
      s1_a   <= in_a;
      s1_b   <= in_b;
    end else if (s1_retire) begin
      s1_vld <= 1'b0;
    end
  end

  // carry_flag only moves on retire, so adder inputs stay stable while S1 is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            carry_flag <= 1'b0;
    else if (s1_retire) carry_flag <= add_c_out;
  end

  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_c_in = 1'b0;
    if (s1_vld) begin
      add_a = s1_a;
      case (s1_op)
        OP_ADD: begin add_b = s1_b;  add_c_in = 1'b0;       end
        OP_SUB: begin add_b = ~s1_b; add_c_in = 1'b1;       end
        OP_ADC: begin add_b = s1_b;  add_c_in = carry_flag; end
        default: begin add_b = ~s1_b; add_c_in = carry_flag; end
      endcase
    end
  end

  always_comb begin
    res_v   = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    res_sum = add_sum;
`ifdef ADD_SUB_SAT_EN
    if (res_v && !s1_op[1])
      res_sum = add_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    push_dat.sum   = res_sum;
    push_dat.flags = {res_sum[WIDTH-1], (res_sum == '0), add_c_out, res_v};
  end

  sync_fifo #(
    .W     ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (s1_vld),
    .push_rdy (fifo_push_rdy),
    .push_dat (push_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head_dat)
  );

  assign out_sum   = head_dat.sum;
  assign out_flags = head_dat.flags;
endmodule

// File: tb/tb_add_sub_issue_stage.sv
// Scoreboard bench for add_sub_issue_stage with a behavioural adder on the add_* ports.
module tb_add_sub_issue_stage;
  localparam int W = 64;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBB = 2'b11;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic         add_c_in, add_c_out, carry_flag;
  logic [3:0]   out_flags;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [3:0]   flags;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  logic model_carry = 1'b0;
  logic rand_done;

  always #5 clk = ~clk;

  always_comb {add_c_out, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c_in};

  add_sub_issue_stage #(.WIDTH(W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
    .add_sum(add_sum), .add_c_out(add_c_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags), .carry_flag(carry_flag)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cf);
    logic [W-1:0] bb, s;
    logic [W:0]   full;
    logic         v;
    exp_t         e;
    bb   = op[0] ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (op[1] ? cf : op[0])};
    s    = full[W-1:0];
    v    = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
`ifdef ADD_SUB_SAT_EN
    if (v && !op[1]) s = a[W-1] ? MINV : MAXV;
`endif
    e.sum   = s;
    e.flags = {s[W-1], (s == '0), full[W], v};
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] esum, input logic [3:0] eflags);
    int n = 0;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("send_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) begin
      e.sum = esum;
      e.flags = eflags;
      sb.push_back(e);
      model_carry = eflags[1];
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("drain_left", W'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 64'd1;
      2: return ONES;
      3: return MINV;
      4: return MAXV;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_flags", {60'd0, out_flags}, {60'd0, e.flags});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = ADD; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_carry", {63'd0, carry_flag}, 64'd0);
    check("rst_add_a", add_a, 64'd0);
    check("rst_add_c_in", {63'd0, add_c_in}, 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_out_flags", {60'd0, out_flags}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // basic add and latency
    send(ADD, 64'd5, 64'd7, 64'd12, 4'b0000);
    check("s1_add_a", add_a, 64'd5);
    check("s1_add_b", add_b, 64'd7);
    check("s1_add_c_in", {63'd0, add_c_in}, 64'd0);
    check("lat_not_yet", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 check("lat_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // 128-bit chain: the ADC must see the carry of the ADD retiring on its accept edge
    send(ADD, ONES, 64'd1, 64'd0, 4'b0110);
    send(ADC, 64'd0, 64'd0, 64'd1, 4'b0000);
    check("chain_c_in", {63'd0, add_c_in}, 64'd1);
    drain();
    check("chain_carry_end", {63'd0, carry_flag}, 64'd0);

    // subtraction, borrow and signed overflow
    send(SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
`ifdef ADD_SUB_SAT_EN
    send(SUB, MINV, 64'd1, MINV, 4'b1011);
`else
    send(SUB, MINV, 64'd1, MAXV, 4'b0011);
`endif
    send(SBB, 64'd10, 64'd3, 64'd7, 4'b0010);
    drain();

    // backpressure, then full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    fork
      begin
        send(ADD, 64'd1, 64'd1, 64'd2, 4'b0000);
        send(ADD, 64'd2, 64'd2, 64'd4, 4'b0000);
        send(ADD, 64'd3, 64'd3, 64'd6, 4'b0000);
        send(ADD, 64'd4, 64'd4, 64'd8, 4'b0000);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_hold_a", add_a, 64'd3);
        @(negedge clk);
        check("bp_stable_a", add_a, 64'd3);
        check("bp_stable_b", add_b, 64'd3);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_push_rdy", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 check("full_s1_next", add_a, 64'd4);
        check("full_still_valid", {63'd0, out_valid}, 64'd1);
      end
    join
    drain();

    // reset mid-stream with S1 and FIFO occupied, carry set
    out_ready = 1'b0;
    send(ADD, ONES, ONES, ONES - 64'd1, 4'b1010);
    send(ADD, ONES, 64'd1, 64'd0, 4'b0110);
    send(ADC, 64'd5, 64'd5, 64'd11, 4'b0000);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_carry", {63'd0, carry_flag}, 64'd0);
    check("mid_rst_add_a", add_a, 64'd0);
    sb.delete();
    model_carry = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(ADC, 64'd1, 64'd1, 64'd2, 4'b0000);
    drain();

    // random ops under random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [1:0]   op;
          logic [W-1:0] a, b;
          exp_t         e;
          op = 2'($urandom_range(0, 3));
          a = pick();
          b = pick();
          e = model(op, a, b, model_carry);
          send(op, a, b, e.sum, e.flags);
        end
        rand_done = 1'b1;
      end
      begin
        int n = 0;
        while (!rand_done && n < 5000) begin
          n++;
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
